// File: rtl/axis_uart_pkg.sv
// Shared UART definitions: FSM state encoding, legal parameter ranges and the
// parity helper, used by both the transmitter and the receiver.
package axis_uart_pkg;

    localparam int NBITS_MIN      = 5;
    localparam int NBITS_MAX      = 9;
    localparam int OVERSAMPLE_MIN = 4;
    localparam int OVERSAMPLE_MAX = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Unused upper bits must be zero so they do not disturb the reduction.
    function automatic logic parity_of(logic [NBITS_MAX-1:0] bits, logic odd);
        return (^bits) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit oversample counter: advances on tick, wraps after OVERSAMPLE ticks and
// flags the terminal count so the caller can end the current bit on that tick.
module uart_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic tick_i,
    output logic tc_o
);

    localparam int CW = $clog2(OVERSAMPLE);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o = (cnt_q == CW'(OVERSAMPLE - 1));

    // NOTE: every signal assigned in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = tc_o ? '0 : cnt_q + CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axis_uart_tx.sv
// AXI-Stream fed UART transmitter: start bit, NBITS data bits LSB first, optional
// parity, one or two stop bits. Frame settings are captured at acceptance.
module axis_uart_tx
    import axis_uart_pkg::*;
#(
    parameter int NBITS      = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [NBITS-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             two_stop,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    localparam int IDX_W = $clog2(NBITS);

    uart_state_e      state_q;
    logic [NBITS-1:0] data_q;
    logic             par_en_q;
    logic             par_odd_q;
    logic             two_stop_q;
    logic             stop2_q;
    logic [IDX_W-1:0] bit_idx_q;
    logic [IDX_W-1:0] bit_idx_d;
    logic             tx_q;
    logic             busy_q;
    logic             done_q;
    logic             accept;
    logic             timing;
    logic             tc;
    logic             bit_end;

    assign s_axis_tready = (state_q == ST_IDLE);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign timing        = (state_q != ST_IDLE);
    assign bit_end       = tick && tc && timing;
    assign bit_idx_d     = bit_idx_q + IDX_W'(1);

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

    uart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (accept),
        .tick_i  (tick && timing),
        .tc_o    (tc)
    );

    // NOTE: the async reset clears every register, including the data latch,
    // so the line is forced idle the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (s_axis_tvalid) begin
                        data_q     <= s_axis_tdata;
                        par_en_q   <= parity_en;
                        par_odd_q  <= parity_odd;
                        two_stop_q <= two_stop;
                        stop2_q    <= 1'b0;
                        bit_idx_q  <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        tx_q      <= data_q[0];
                        bit_idx_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q == IDX_W'(NBITS - 1)) begin
                            if (par_en_q) begin
                                tx_q    <= parity_of(NBITS_MAX'(data_q), par_odd_q);
                                state_q <= ST_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_d;
                            tx_q      <= data_q[bit_idx_d];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (two_stop_q && !stop2_q) begin
                            stop2_q <= 1'b1;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Bench for axis_uart_tx: an 8-bit/16x and a 5-bit/4x instance share stimulus;
// each frame is compared tick by tick against an expected bit list.
module tb_axis_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, tick, tvalid, sel, pen, podd, two;
    logic [8:0] tdata;
    logic       rdy8, tx8, busy8, done8;
    logic       rdy5, tx5, busy5, done5;
    logic       tv8, tv5, rdy_m, tx_m, busy_m, done_m;

    assign tv8    = tvalid & ~sel;
    assign tv5    = tvalid & sel;
    assign rdy_m  = sel ? rdy5  : rdy8;
    assign tx_m   = sel ? tx5   : tx8;
    assign busy_m = sel ? busy5 : busy8;
    assign done_m = sel ? done5 : done8;

    axis_uart_tx #(.NBITS(8), .OVERSAMPLE(16)) dut8 (
        .clk(clk), .rst(rst), .tick(tick), .s_axis_tdata(tdata[7:0]),
        .s_axis_tvalid(tv8), .s_axis_tready(rdy8), .parity_en(pen),
        .parity_odd(podd), .two_stop(two), .tx(tx8), .busy(busy8), .tx_done(done8)
    );

    axis_uart_tx #(.NBITS(5), .OVERSAMPLE(4)) dut5 (
        .clk(clk), .rst(rst), .tick(tick), .s_axis_tdata(tdata[4:0]),
        .s_axis_tvalid(tv5), .s_axis_tready(rdy5), .parity_en(pen),
        .parity_odd(podd), .two_stop(two), .tx(tx5), .busy(busy5), .tx_done(done5)
    );

    int total = 0;
    int bad   = 0;
    int div   = 1;
    int phase = 0;
    bit tick_seen;

    typedef struct {
        logic [8:0] d;
        bit         p_en;
        bit         p_odd;
        bit         two_s;
        bit         scr;
        bit         exp_par;
        int         exp_ticks;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive tick for the coming edge, then sample 1 time unit after it.
    task automatic step();
        tick  = (phase == 0);
        phase = (phase + 1 >= div) ? 0 : phase + 1;
        @(posedge clk);
        tick_seen = tick;
        #1;
    endtask

    // Sends one frame on the selected instance and compares the line, busy, ready
    // and done against the bit list built from the frame rules.
    task automatic run_frame(input bit s, input logic [8:0] d, input bit p_en,
                             input bit p_odd, input bit two_s, input bit scr,
                             input bit hold, input logic [8:0] nd,
                             output int waited, output bit ok, output int ticks,
                             output int span, output bit par_seen);
        int nb, ovs, n, ones, c, clks, start_clk;
        bit fb[16];
        bit acc, r, fin, scrambled, e;
        nb = s ? 5 : 8;
        ovs = s ? 4 : 16;
        ones = 0;
        fb[0] = 1'b0;
        for (int i = 0; i < nb; i++) begin
            fb[i+1] = d[i];
            ones += int'(d[i]);
        end
        n = nb + 1;
        if (p_en) begin
            fb[n] = ((ones % 2) == 1) ^ p_odd;
            n++;
        end
        fb[n] = 1'b1;
        n++;
        if (two_s) begin
            fb[n] = 1'b1;
            n++;
        end
        ok = 1'b0; ticks = 0; span = 0; par_seen = 1'b0; waited = 0;
        sel = s; tdata = d; pen = p_en; podd = p_odd; two = two_s; tvalid = 1'b1;
        #1;
        acc = 1'b0;
        while (!acc && waited < 200) begin
            r = rdy_m;
            step();
            waited++;
            acc = r;
        end
        if (!acc) begin
            check("accept_timeout", 0, 1);
            tvalid = 1'b0;
            return;
        end
        if (hold) tdata = nd;
        else tvalid = 1'b0;
        ok = (tx_m === 1'b0) && (busy_m === 1'b1) && (rdy_m === 1'b0) && (done_m === 1'b0);
        c = 0; clks = 0; fin = 1'b0; start_clk = 0; scrambled = 1'b0;
        while (!fin && clks < 3000) begin
            step();
            clks++;
            if (tick_seen) c++;
            if (scr && !scrambled && c >= 2 * ovs) begin
                tdata = ~tdata; pen = ~pen; podd = ~podd; two = ~two;
                scrambled = 1'b1;
            end
            if (c == ovs && start_clk == 0) start_clk = clks;
            if (c < n * ovs) begin
                e = fb[c / ovs];
                if (tx_m !== e || busy_m !== 1'b1 || rdy_m !== 1'b0 || done_m !== 1'b0) ok = 1'b0;
                if (p_en && c == (nb + 1) * ovs + ovs / 2) par_seen = tx_m;
            end else begin
                fin = 1'b1;
                if (!(done_m === 1'b1 && busy_m === 1'b0 && tx_m === 1'b1 && rdy_m === 1'b1)) ok = 1'b0;
            end
        end
        if (!fin) ok = 1'b0;
        ticks = c;
        span = clks - start_clk;
        if (!hold) begin
            step();
            if (done_m !== 1'b0 || tx_m !== 1'b1 || busy_m !== 1'b0) ok = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited, ticks, span, c, n;
        bit ok, par, idle_ok, done_ok, acc, r;

        tbl[0] = '{9'h055, 0, 0, 0, 0, 0, 160};
        tbl[1] = '{9'h007, 1, 0, 0, 0, 1, 176};
        tbl[2] = '{9'h007, 1, 1, 0, 0, 0, 176};
        tbl[3] = '{9'h007, 1, 0, 1, 0, 1, 192};
        tbl[4] = '{9'h0A1, 0, 0, 0, 1, 0, 160};
        tbl[5] = '{9'h03C, 1, 1, 1, 1, 1, 192};
        tbl[6] = '{9'h0FF, 1, 0, 0, 0, 0, 176};
        tbl[7] = '{9'h000, 1, 1, 0, 0, 1, 176};

        rst = 1'b1; tick = 1'b0; tvalid = 1'b0; sel = 1'b0; tdata = '0;
        pen = 1'b0; podd = 1'b0; two = 1'b0;
        repeat (3) step();
        check("rst_tx8", tx8, 1);
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_ready8", rdy8, 1);
        check("rst_tx5", tx5, 1);

        // A beat offered only while reset is held, then withdrawn, must never go out.
        tdata = 9'h033; tvalid = 1'b1;
        repeat (2) step();
        tvalid = 1'b0;
        rst = 1'b0;
        idle_ok = 1'b1;
        repeat (40) begin
            step();
            if (tx8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0 || rdy8 !== 1'b1) idle_ok = 1'b0;
        end
        check("idle_ticks_ignored", idle_ok, 1);

        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_frame(1'b0, tbl[i].d, tbl[i].p_en, tbl[i].p_odd, tbl[i].two_s,
                      tbl[i].scr, 1'b0, 9'h000, waited, ok, ticks, span, par);
            if (i == 0) check("first_accept_after_rst", waited, 1);
            check($sformatf("vec%0d_frame", i), ok, 1);
            check($sformatf("vec%0d_len", i), ticks, tbl[i].exp_ticks);
            if (tbl[i].p_en) check($sformatf("vec%0d_parity", i), par, tbl[i].exp_par);
        end

        run_frame(1'b0, 9'h0A1, 0, 0, 0, 0, 1'b1, 9'h03C, waited, ok, ticks, span, par);
        check("b2b_first_frame", ok, 1);
        run_frame(1'b0, 9'h03C, 0, 0, 0, 0, 1'b0, 9'h000, waited, ok, ticks, span, par);
        check("b2b_gap_clocks", waited, 1);
        check("b2b_second_frame", ok, 1);

        // Reset in the middle of data bit 3 (0xB6 bit 3 is 0, so the line is low).
        sel = 1'b0; div = 1; tdata = 9'h0B6; pen = 1'b0; podd = 1'b0; two = 1'b0;
        tvalid = 1'b1;
        #1;
        acc = 1'b0; n = 0;
        while (!acc && n < 50) begin
            r = rdy8;
            step();
            n++;
            acc = r;
        end
        tvalid = 1'b0;
        c = 0; n = 0;
        while (c < 4 * 16 + 8 && n < 500) begin
            step();
            n++;
            if (tick_seen) c++;
        end
        check("pre_rst_tx_bit3", tx8, 0);
        check("pre_rst_busy", busy8, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_tx", tx8, 1);
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_ready", rdy8, 1);
        done_ok = 1'b1;
        repeat (3) begin
            step();
            if (done8 !== 1'b0 || tx8 !== 1'b1) done_ok = 1'b0;
        end
        rst = 1'b0;
        idle_ok = 1'b1;
        repeat (40) begin
            step();
            if (done8 !== 1'b0 || tx8 !== 1'b1 || busy8 !== 1'b0) idle_ok = 1'b0;
        end
        check("rst_no_done", done_ok, 1);
        check("rst_not_resumed", idle_ok, 1);
        run_frame(1'b0, 9'h05A, 1, 0, 0, 0, 1'b0, 9'h000, waited, ok, ticks, span, par);
        check("post_rst_frame", ok, 1);

        div = 3; phase = 0;
        run_frame(1'b1, 9'h01F, 0, 0, 0, 0, 1'b0, 9'h000, waited, ok, ticks, span, par);
        check("n5_frame", ok, 1);
        check("n5_len_ticks", ticks, 28);
        check("n5_data_stop_clocks", span, 72);

        for (int k = 0; k < 20; k++) begin
            bit s, pe, po, ts, sc;
            logic [8:0] d;
            int exp_len;
            s = 1'($urandom_range(0, 1));
            d = 9'($urandom) & (s ? 9'h01F : 9'h0FF);
            pe = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 1));
            ts = 1'($urandom_range(0, 1));
            sc = 1'($urandom_range(0, 1));
            div = $urandom_range(1, 3);
            phase = $urandom_range(0, div - 1);
            exp_len = ((s ? 5 : 8) + 2 + int'(pe) + int'(ts)) * (s ? 4 : 16);
            run_frame(s, d, pe, po, ts, sc, 1'b0, 9'h000, waited, ok, ticks, span, par);
            check($sformatf("rand%0d_frame", k), ok, 1);
            check($sformatf("rand%0d_len", k), ticks, exp_len);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
